fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the single-issue RV32 core. It owns the program counter and issues word requests to instruction memory. Returned words are buffered in a small in-order FIFO and handed to the control decoder with a valid/ready handshake. A redirect from branch/jump resolution flushes everything in flight and restarts fetch at the new PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2; also the cap on outstanding memory requests

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch word address, bits [1:0] always 0
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response word valid; responses in request order, latency ≥1 cycle
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle pulse from branch/jump resolution
- redirect_pc  in  32  new fetch target
- instr_valid  out  1  instr/instr_pc valid for the decoder
- instr  out  32  instruction word to the decoder
- instr_pc  out  32  address of instr
- instr_ready  in  1  decoder consumes instr this cycle
- misalign  out  1  sticky misaligned-redirect flag; see Configuration

## Operation
- State: pc (next request address), outstanding count (0..FIFO_DEPTH), drop count (0..FIFO_DEPTH), FIFO of {pc, word} with read/write pointers and a count.
- Request issue: imem_req_valid = !redirect_valid && !halted && (outstanding + fifo_count < FIFO_DEPTH). The credit rule guarantees every response has a FIFO slot, so responses are never back-pressured.
- imem_req_valid && imem_req_ready: pc += 4 (32-bit wrap, 0xFFFF_FFFC→0x0000_0000) and outstanding += 1.
- Response with drop count > 0: word discarded, drop count -= 1, outstanding -= 1. Otherwise word written with its fetch PC; the PC comes from a shadow queue of issued addresses, or equivalently a response-PC register that advances by 4.
- Output: FIFO head drives instr/instr_pc; instr_valid = fifo_count != 0. instr_valid && instr_ready pops the head.
- Simultaneous push and pop: count unchanged. A full FIFO cannot receive a push, by the credit rule.
- Redirect (edge where redirect_valid=1): FIFO emptied; pc ← redirect_pc; drop count ← all outstanding responses not returning this cycle; any response arriving this cycle is dropped. A pop in the same cycle counts as consumed. No request issues in the redirect cycle.
- Reset (asynchronous, any time): pc=RESET_PC, all counts 0, FIFO empty, misalign=0.

## Timing
- Reset outputs: imem_req_valid=0 while rst_n=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misalign=0.
- First cycle after rst_n rises: imem_req_valid=1, addr=RESET_PC.
- Response at edge N → instr_valid=1 from cycle N+1 (one registered stage); no combinational path rsp→instr.
- Redirect at edge N → cycle N+1: instr_valid=0, imem_req_addr=redirect_pc, request valid if credits allow.
- Steady state with 1-cycle memory and instr_ready=1: one instruction per cycle.
- No combinational path from instr_ready to imem_req_valid; credit uses registered counts.

## Configuration
- FETCH_MISALIGN_CHK_EN defined: a redirect with redirect_pc[1:0]≠0 sets misalign (sticky until reset) and halts fetch, so no further requests issue. The FIFO is still flushed, and later redirects are ignored.
- Undefined: redirect_pc[1:0] is forced to 00, misalign is tied 0, and the halt logic is absent.

## Test plan
- Reset with RESET_PC=0x100, 1-cycle memory, instr_ready=1 → instr_pc sequence 0x100,0x104,0x108 on consecutive cycles; first instr_valid two cycles after the first request.
- instr_ready=0 for 10 cycles → exactly FIFO_DEPTH requests issued, then imem_req_valid=0. Releasing instr_ready → words delivered in order with none lost.
- 3-cycle memory latency with 2 requests outstanding, redirect to 0x400 → both stale responses dropped, next instr_pc=0x400.
- Redirect in the same cycle as imem_rsp_valid and an instr pop → response discarded, pop completes, next request addr=redirect_pc.
- Fetch from 0xFFFF_FFFC → next request addr 0x0000_0000.
- redirect_pc=0x202: with FETCH_MISALIGN_CHK_EN, misalign=1 and no further requests; without it, the next request addr is 0x200 and misalign stays 0.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the single-issue RV32 core. Owns the program
//   counter, issues word requests to instruction memory, buffers returned
//   words together with their fetch PC in a small in-order FIFO and hands
//   them to the decoder with a valid/ready handshake. A redirect flushes all
//   work in flight and restarts fetch at the new PC.
//
//   Requests are credit limited: a request is only issued while
//   outstanding + buffered < FIFO_DEPTH, so every response is guaranteed a
//   FIFO slot and the memory response path is never back-pressured.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a redirect to a non word-aligned PC raises the sticky
//               misalign flag and halts fetch (later redirects are ignored).
//   undefined : redirect_pc[1:0] is forced to 00 and misalign is tied low.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2); also the
//               cap on outstanding memory requests
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   imem_req_valid/addr/ready      word fetch request to instruction memory
//   imem_rsp_valid/data            in-order response words, latency >= 1
//   redirect_valid/pc              one-cycle redirect from branch resolution
//   instr_valid/instr/instr_pc     buffered instruction to the decoder
//   instr_ready                    decoder consumes the head this cycle
//   misalign                       sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  // Architectural state
  logic [31:0]      pc_r;
  logic [31:0]      rsp_pc_r;
  logic [CNT_W-1:0] out_cnt_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic [CNT_W-1:0] fifo_cnt_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [31:0]      fifo_pc_r   [FIFO_DEPTH];
  logic [31:0]      fifo_word_r [FIFO_DEPTH];

  // Combinational control
  logic             redirect_take_s;
  logic             halted_s;
  logic [31:0]      target_pc_s;
  logic [CNT_W:0]   credit_used_s;
  logic             req_fire_s;
  logic             rsp_drop_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] out_cnt_nxt_s;
  logic [CNT_W-1:0] drop_cnt_nxt_s;
  logic [CNT_W-1:0] fifo_cnt_nxt_s;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_r;
  logic redirect_bad_s;

  // Misalignment detection; once halted, redirects are no longer honoured
  always_comb begin
    redirect_bad_s  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    halted_s        = misalign_r;
    redirect_take_s = redirect_valid && !misalign_r;
  end

  // Sticky misalign flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
    end else if (redirect_take_s && redirect_bad_s) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign misalign = misalign_r;
`else
  // Without the checker every redirect is honoured and fetch never halts
  always_comb begin
    halted_s        = 1'b0;
    redirect_take_s = redirect_valid;
  end

  assign misalign = 1'b0;
`endif

  // Request credit and handshake qualifiers
  always_comb begin
    // Low address bits are dropped: fetch is always word aligned
    target_pc_s   = redirect_pc & 32'hFFFF_FFFC;
    credit_used_s = {1'b0, out_cnt_r} + {1'b0, fifo_cnt_r};
    req_fire_s    = imem_req_valid && imem_req_ready;
    // A response is discarded when it belongs to a flushed request, including
    // one that lands in the same cycle as the redirect itself
    rsp_drop_s    = imem_rsp_valid && (redirect_take_s || (drop_cnt_r != {CNT_W{1'b0}}));
    push_s        = imem_rsp_valid && !rsp_drop_s;
    pop_s         = instr_valid && instr_ready;
  end

  // Credit uses registered counts only, so instr_ready never reaches the request.
  // Gating with rst_n keeps the request low for the whole reset interval.
  assign imem_req_valid = rst_n && !redirect_valid && !halted_s && (credit_used_s < DEPTH_C);
  assign imem_req_addr  = pc_r;

  // Next-state values of the outstanding, drop and buffer counters
  always_comb begin
    out_cnt_nxt_s = out_cnt_r + CNT_W'(req_fire_s) - CNT_W'(imem_rsp_valid);
    if (redirect_take_s) begin
      // Everything still in flight after this edge must be discarded
      drop_cnt_nxt_s = out_cnt_r - CNT_W'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_cnt_r != {CNT_W{1'b0}})) begin
      drop_cnt_nxt_s = drop_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_nxt_s = drop_cnt_r;
    end
    if (redirect_take_s) begin
      fifo_cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      fifo_cnt_nxt_s = fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Fetch PC and response-PC tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r     <= RESET_PC;
      rsp_pc_r <= RESET_PC;
    end else if (redirect_take_s) begin
      // The first response kept after a redirect belongs to the new target
      pc_r     <= target_pc_s;
      rsp_pc_r <= target_pc_s;
    end else begin
      pc_r     <= req_fire_s ? (pc_r + 32'd4) : pc_r;
      rsp_pc_r <= push_s ? (rsp_pc_r + 32'd4) : rsp_pc_r;
    end
  end

  // Outstanding, drop and buffer occupancy counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_r  <= {CNT_W{1'b0}};
      drop_cnt_r <= {CNT_W{1'b0}};
      fifo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      out_cnt_r  <= out_cnt_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
      fifo_cnt_r <= fifo_cnt_nxt_s;
    end
  end

  // Buffer read/write pointers; a redirect empties the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
    end else if (redirect_take_s) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
    end else begin
      rd_ptr_r <= pop_s  ? (rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1}) : rd_ptr_r;
      wr_ptr_r <= push_s ? (wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1}) : wr_ptr_r;
    end
  end

  // Buffer storage; cleared on reset so instr/instr_pc read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_pc_r[i]   <= 32'h0000_0000;
        fifo_word_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      fifo_pc_r[wr_ptr_r]   <= rsp_pc_r;
      fifo_word_r[wr_ptr_r] <= imem_rsp_data;
    end else begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_pc_r[i]   <= fifo_pc_r[i];
        fifo_word_r[i] <= fifo_word_r[i];
      end
    end
  end

  // Decoder side: buffer head straight from registers
  assign instr_valid = (fifo_cnt_r != {CNT_W{1'b0}});
  assign instr       = fifo_word_r[rd_ptr_r];
  assign instr_pc    = fifo_pc_r[rd_ptr_r];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit (RESET_PC=0x100, FIFO_DEPTH=2).
//   A memory model returns addr ^ 0xDEADBEEF after a configurable latency.
//   A reference PC model pushes the expected {pc, word} into a scoreboard
//   queue whenever a request is accepted; every decoder pop is compared
//   against the queue head, and a redirect clears the queue.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;
  int reqs   = 0;
  int pops   = 0;

  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] model_pc   = 32'h0000_0100;
  bit          model_halt = 1'b0;

  fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // One clock cycle: present memory response, score pops and requests, advance.
  // Called just after a falling edge with this cycle's inputs already set.
  task automatic cycle();
    logic [63:0] e;
    if (cyc > 5000) begin
      $display("FAIL timeout: cycle=%0d limit=5000", cyc);
      $fatal(1);
    end
    if (mem_addr_q.size() != 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_addr_q[0] ^ 32'hDEAD_BEEF;
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0000_0000;
    end
    #1;
    if (redirect_valid) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_in_redirect: got %b expected 0", imem_req_valid);
      end
    end
    if (instr_valid && instr_ready) begin
      pops++;
      pop_pc_q.push_back(instr_pc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pc=%h word=%h expected no instruction", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          errors++;
          $display("FAIL pop_order: got pc=%h word=%h expected pc=%h word=%h",
                   instr_pc, instr, e[63:32], e[31:0]);
        end
      end
    end
    if (redirect_valid && !model_halt) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) model_halt = 1'b1;
`endif
      model_pc = {redirect_pc[31:2], 2'b00};
    end
    if (imem_req_valid && imem_req_ready) begin
      reqs++;
      checks++;
      if (model_halt) begin
        errors++;
        $display("FAIL req_while_halted: got addr=%h expected no request", imem_req_addr);
      end else if (imem_req_addr !== model_pc) begin
        errors++;
        $display("FAIL req_addr: got %h expected %h", imem_req_addr, model_pc);
      end
      exp_q.push_back({model_pc, model_pc ^ 32'hDEAD_BEEF});
      mem_addr_q.push_back(imem_req_addr);
      mem_due_q.push_back(cyc + lat);
      model_pc = model_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL rst_req_addr: got %h expected 00000100", imem_req_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc: got %h expected 0", instr_pc); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b expected 0", misalign); end
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_stream();
    int first_valid = -1;
    int p0 = pop_pc_q.size();
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL first_req_addr: got %h expected 00000100", imem_req_addr); end
    for (int i = 0; i < 12; i++) begin
      if (first_valid < 0 && instr_valid) first_valid = cyc;
      cycle();
    end
    checks++; if (first_valid != 2) begin errors++; $display("FAIL first_instr_cycle: got %0d expected 2", first_valid); end
    checks++;
    if (pop_pc_q.size() < p0 + 3) begin
      errors++; $display("FAIL stream_pops: got %0d expected >=3", pop_pc_q.size() - p0);
    end else if (pop_pc_q[p0] !== 32'h100 || pop_pc_q[p0+1] !== 32'h104 || pop_pc_q[p0+2] !== 32'h108) begin
      errors++; $display("FAIL stream_pcs: got %h %h %h expected 00000100 00000104 00000108",
                         pop_pc_q[p0], pop_pc_q[p0+1], pop_pc_q[p0+2]);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    int p0;
    instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    cycle();
    redirect_valid = 1'b0;
    r0 = reqs;
    for (int i = 0; i < 10; i++) cycle();
    checks++; if (reqs - r0 != 2) begin errors++; $display("FAIL stall_req_count: got %0d expected 2", reqs - r0); end
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); end
    p0 = pop_pc_q.size();
    instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    checks++;
    if (pop_pc_q.size() < p0 + 2) begin
      errors++; $display("FAIL release_pops: got %0d expected >=2", pop_pc_q.size() - p0);
    end else if (pop_pc_q[p0] !== 32'h300 || pop_pc_q[p0+1] !== 32'h304) begin
      errors++; $display("FAIL release_pcs: got %h %h expected 00000300 00000304", pop_pc_q[p0], pop_pc_q[p0+1]);
    end
  endtask

  task automatic test_redirect_latency();
    bit found = 1'b0;
    int p0;
    lat = 3;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mem_addr_q.size() == 2 && mem_due_q[0] > cyc) found = 1'b1;
      else cycle();
    end
    checks++; if (!found) begin errors++; $display("FAIL lat3_two_outstanding: got 0 expected 1"); end
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL lat3_valid_after_redirect: got %b expected 0", instr_valid); end
    checks++; if (imem_req_addr !== 32'h400) begin errors++; $display("FAIL lat3_addr_after_redirect: got %h expected 00000400", imem_req_addr); end
    p0 = pop_pc_q.size();
    for (int i = 0; i < 14; i++) cycle();
    checks++;
    if (pop_pc_q.size() <= p0 || pop_pc_q[p0] !== 32'h400) begin
      errors++; $display("FAIL lat3_first_pc: got %h expected 00000400", (pop_pc_q.size() > p0) ? pop_pc_q[p0] : 32'hXXXX_XXXX);
    end
    lat = 1;
  endtask

  task automatic test_redirect_collide();
    bit found = 1'b0;
    int pb;
    int p0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid && mem_addr_q.size() != 0 && mem_due_q[0] <= cyc) found = 1'b1;
      else cycle();
    end
    checks++; if (!found) begin errors++; $display("FAIL collide_setup: got 0 expected 1"); end
    pb = pops;
    redirect_valid = 1'b1; redirect_pc = 32'h800;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (pops != pb + 1) begin errors++; $display("FAIL collide_pop: got %0d expected 1", pops - pb); end
    checks++; if (imem_req_addr !== 32'h800) begin errors++; $display("FAIL collide_addr: got %h expected 00000800", imem_req_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL collide_flush: got %b expected 0", instr_valid); end
    p0 = pop_pc_q.size();
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (pop_pc_q.size() <= p0 || pop_pc_q[p0] !== 32'h800) begin
      errors++; $display("FAIL collide_first_pc: got %h expected 00000800", (pop_pc_q.size() > p0) ? pop_pc_q[p0] : 32'hXXXX_XXXX);
    end
  endtask

  task automatic test_wrap();
    bit seen = 1'b0;
    int ra;
    int p0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    p0 = pop_pc_q.size();
    checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start_addr: got %h expected fffffffc", imem_req_addr); end
    for (int i = 0; i < 10 && !seen; i++) begin
      ra = reqs;
      cycle();
      if (reqs > ra) seen = 1'b1;
    end
    checks++; if (!seen || imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got %h expected 00000000", imem_req_addr); end
    for (int i = 0; i < 8; i++) cycle();
    checks++;
    if (pop_pc_q.size() < p0 + 2 || pop_pc_q[p0] !== 32'hFFFF_FFFC || pop_pc_q[p0+1] !== 32'h0) begin
      errors++; $display("FAIL wrap_pcs: got %0d pops expected fffffffc then 00000000", pop_pc_q.size() - p0);
    end
  endtask

  task automatic test_misalign();
    int p0;
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    cycle();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    begin
      int r0;
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_set: got %b expected 1", misalign); end
      r0 = reqs;
      for (int i = 0; i < 6; i++) cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h500;
      cycle();
      redirect_valid = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      checks++; if (reqs != r0) begin errors++; $display("FAIL misalign_halt: got %0d requests expected 0", reqs - r0); end
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %b expected 1", misalign); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL misalign_flush: got %b expected 0", instr_valid); end
    end
`else
    checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL align_addr: got %h expected 00000200", imem_req_addr); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL align_misalign: got %b expected 0", misalign); end
    p0 = pop_pc_q.size();
    for (int i = 0; i < 8; i++) cycle();
    checks++;
    if (pop_pc_q.size() <= p0 || pop_pc_q[p0] !== 32'h200) begin
      errors++; $display("FAIL align_first_pc: got %h expected 00000200", (pop_pc_q.size() > p0) ? pop_pc_q[p0] : 32'hXXXX_XXXX);
    end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL align_misalign_later: got %b expected 0", misalign); end
`endif
    p0 = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_redirect_collide();
    test_wrap();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
